npc_branch_unit: RTL

//  Owns the IF-stage PC register and resolves branches/jumps in ID using the

---
 rtl/npc_pkg.sv | 23 ++
 rtl/br_cond_eval.sv | 39 +++
 rtl/npc_branch_unit.sv | 102 ++++++++++
 3 files changed

// File: rtl/npc_pkg.sv
// Shared branch-class encodings and FSM state type for the next-PC unit.
package npc_pkg;

  localparam logic [3:0] BR_NONE = 4'd0;
  localparam logic [3:0] BR_BEQ  = 4'd1;
  localparam logic [3:0] BR_BNE  = 4'd2;
  localparam logic [3:0] BR_BGEZ = 4'd3;
  localparam logic [3:0] BR_BGTZ = 4'd4;
  localparam logic [3:0] BR_BLEZ = 4'd5;
  localparam logic [3:0] BR_BLTZ = 4'd6;
  localparam logic [3:0] BR_J    = 4'd7;
  localparam logic [3:0] BR_JAL  = 4'd8;
  localparam logic [3:0] BR_JR   = 4'd9;
  localparam logic [3:0] BR_JALR = 4'd10;
  localparam logic [3:0] BR_BEQL = 4'd11;
  localparam logic [3:0] BR_BNEL = 4'd12;

  typedef enum logic {
    SEQ   = 1'b0,
    ANNUL = 1'b1
  } state_t;

endpackage

// File: rtl/br_cond_eval.sv
// Maps branch class plus comparator flags to a take/not-take condition.
// BEQL/BNEL are decoded only when BRANCH_LIKELY_EN is defined.
module br_cond_eval
  import npc_pkg::*;
(
  input  logic [3:0] br_type,
  input  logic       equal,
  input  logic       g_or_e,
  input  logic       greater,
  output logic       cond,
  output logic       likely
);

  always_comb begin
    cond   = 1'b0;
    likely = 1'b0;
    case (br_type)
      BR_BEQ:  cond = equal;
      BR_BNE:  cond = ~equal;
      BR_BGEZ: cond = g_or_e;
      BR_BGTZ: cond = greater;
      BR_BLEZ: cond = ~greater;
      BR_BLTZ: cond = ~g_or_e;
      BR_J, BR_JAL, BR_JR, BR_JALR: cond = 1'b1;
`ifdef BRANCH_LIKELY_EN
      BR_BEQL: begin
        cond   = equal;
        likely = 1'b1;
      end
      BR_BNEL: begin
        cond   = ~equal;
        likely = 1'b1;
      end
`endif
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/npc_branch_unit.sv
// IF-stage PC register with ID-stage branch resolution, stall hold, delay-slot
// annulment for branch-likely (BRANCH_LIKELY_EN) and a taken-transfer counter.
module npc_branch_unit
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [3:0]       br_type,
  input  logic             equal,
  input  logic             g_or_e,
  input  logic             greater,
  input  logic [15:0]      imm16,
  input  logic [25:0]      instr_index,
  input  logic [31:0]      jr_target,
  output logic [31:0]      pc,
  output logic [31:0]      link_addr,
  output logic             taken,
  output logic             flush_ds,
  output logic [CNT_W-1:0] taken_cnt
);

  logic             cond;
  logic             likely;
  state_t           state;
  state_t           next_state;
  logic [31:0]      pc_seq;
  logic [31:0]      target;
  logic [31:0]      pc_next;
  logic [CNT_W-1:0] cnt_next;

  br_cond_eval u_cond (
    .br_type (br_type),
    .equal   (equal),
    .g_or_e  (g_or_e),
    .greater (greater),
    .cond    (cond),
    .likely  (likely)
  );

  // The branch sits at pc-4, so pc itself is the delay slot and pc+4 is branch PC+8.
  assign pc_seq    = pc + 32'd4;
  assign link_addr = pc_seq;
  assign taken     = cond & ~stall & (state != ANNUL);

  always_comb begin
    target = pc_seq;
    case (br_type)
      BR_BEQ, BR_BNE, BR_BGEZ, BR_BGTZ, BR_BLEZ, BR_BLTZ, BR_BEQL, BR_BNEL:
        target = pc + {{14{imm16[15]}}, imm16, 2'b00};
      BR_J, BR_JAL:
        target = {pc[31:28], instr_index, 2'b00};
      BR_JR, BR_JALR:
        target = jr_target;
      default:
        target = pc_seq;
    endcase
  end

  // Nothing commits while stalled; the decision is simply re-evaluated later.
  always_comb begin
    next_state = state;
    pc_next    = pc;
    cnt_next   = taken_cnt;
    if (!stall) begin
      case (state)
        SEQ: begin
          pc_next = taken ? target : pc_seq;
          if (taken) cnt_next = taken_cnt + CNT_W'(1);
          if (likely && !cond) next_state = ANNUL;
        end
        ANNUL: begin
          pc_next    = pc_seq;
          next_state = SEQ;
        end
        default: next_state = SEQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SEQ;
      pc        <= RESET_PC;
      taken_cnt <= '0;
    end else begin
      state     <= next_state;
      pc        <= pc_next;
      taken_cnt <= cnt_next;
    end
  end

`ifdef BRANCH_LIKELY_EN
  assign flush_ds = (state == ANNUL);
`else
  assign flush_ds = 1'b0;
`endif

endmodule
